// File: rtl/pattern_csr_bank_if.sv
// Avalon-MM slave-side bundle used by the pattern-search CSR bank.
interface avalon_mm_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   address;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W/8-1:0] byteenable;
    logic                read;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;
    logic                waitrequest;

    modport slave (
        input  address, write, writedata, byteenable, read,
        output readdata, readdatavalid, waitrequest
    );

    modport master (
        output address, write, writedata, byteenable, read,
        input  readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/pattern_csr_bank.sv
// Per-channel CSR bank: double-buffered key patterns with deferred commit,
// channel enables, saturating hit counters and fixed 1-cycle registered reads.
module pattern_csr_bank #(
    parameter int REG_WIDTH    = 32,
    parameter int PAT_REGS     = 3,
    parameter int CHANNELS     = 2,
    parameter int BIT_PER_SYMB = 8,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                                clk_i,
    input  logic                                srst_i,
    avalon_mm_if.slave                          amm_slave_if,
    input  logic [CHANNELS-1:0]                 busy_i,
    input  logic [CHANNELS-1:0]                 match_i,
    output logic [CHANNELS*PAT_REGS*REG_WIDTH-1:0] pattern_o,
    output logic [CHANNELS-1:0]                 wrken_o
);
    localparam int IDX_W = $clog2(PAT_REGS + 2);
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int BYTES = REG_WIDTH / 8;

    if ((REG_WIDTH % 8 != 0) || (REG_WIDTH % BIT_PER_SYMB != 0) ||
        (CNT_WIDTH > REG_WIDTH - 16) || (CHANNELS < 1)) begin : g_param_check
        $error("pattern_csr_bank: inconsistent parameters");
    end

    logic [REG_WIDTH-1:0] shadow_q [CHANNELS][PAT_REGS];
    logic [REG_WIDTH-1:0] shadow_d [CHANNELS][PAT_REGS];
    logic [REG_WIDTH-1:0] active_q [CHANNELS][PAT_REGS];
    logic [REG_WIDTH-1:0] active_d [CHANNELS][PAT_REGS];
    logic [CNT_WIDTH-1:0] cnt_q    [CHANNELS];
    logic [CNT_WIDTH-1:0] cnt_d    [CHANNELS];
    logic [CHANNELS-1:0]  en_q, en_d;
    logic [CHANNELS-1:0]  pend_q, pend_d;
    logic [REG_WIDTH-1:0] rdata_q, rdata_d;
    logic                 rvalid_q, rvalid_d;

    logic [CH_W-1:0]      addr_ch;
    logic [IDX_W-1:0]     addr_idx;
    logic                 addr_ok;
    logic [CHANNELS-1:0]  ch_sel;
    logic [CHANNELS-1:0]  ctrl_wr;

    always_comb begin
        addr_ch  = amm_slave_if.address[IDX_W +: CH_W];
        addr_idx = amm_slave_if.address[IDX_W-1:0];
        addr_ok  = (32'(addr_ch) < CHANNELS) && (32'(addr_idx) <= PAT_REGS + 1);
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            ch_sel[c]  = addr_ok && (addr_ch == CH_W'(c));
            ctrl_wr[c] = amm_slave_if.write && ch_sel[c] && (addr_idx == '0) &&
                         amm_slave_if.byteenable[0];
        end
    end

    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        cnt_d    = cnt_q;
        en_d     = en_q;
        pend_d   = pend_q;
        rdata_d  = '0;
        rvalid_d = amm_slave_if.read;

        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (ctrl_wr[c]) begin
                en_d[c] = amm_slave_if.writedata[0];
            end

            // Copy reads shadow_q, so a shadow write in the same cycle lands only in shadow.
            if (pend_q[c] && !busy_i[c]) begin
                active_d[c] = shadow_q[c];
                pend_d[c]   = 1'b0;
            end else if (ctrl_wr[c] && amm_slave_if.writedata[1]) begin
                pend_d[c] = 1'b1;
            end

            if (ctrl_wr[c] && amm_slave_if.writedata[2]) begin
                cnt_d[c] = '0;
            end else if (match_i[c] && en_q[c] && (cnt_q[c] != '1)) begin
                cnt_d[c] = cnt_q[c] + 1'b1;
            end

            for (int unsigned w = 0; w < PAT_REGS; w++) begin
                if (amm_slave_if.write && ch_sel[c] && (addr_idx == IDX_W'(w + 2))) begin
                    for (int unsigned b = 0; b < BYTES; b++) begin
                        if (amm_slave_if.byteenable[b]) begin
                            shadow_d[c][w][8*b +: 8] = amm_slave_if.writedata[8*b +: 8];
                        end
                    end
                end
            end

            if (amm_slave_if.read && ch_sel[c]) begin
                if (addr_idx == IDX_W'(0)) begin
                    rdata_d[0] = en_q[c];
                end else if (addr_idx == IDX_W'(1)) begin
                    rdata_d[0]              = en_q[c];
                    rdata_d[1]              = pend_q[c];
                    rdata_d[16 +: CNT_WIDTH] = cnt_q[c];
                end
                for (int unsigned w = 0; w < PAT_REGS; w++) begin
                    if (addr_idx == IDX_W'(w + 2)) begin
                        rdata_d = shadow_q[c][w];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            shadow_q <= '{default: '1};
            active_q <= '{default: '1};
            cnt_q    <= '{default: '0};
            en_q     <= '0;
            pend_q   <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
            en_q     <= en_d;
            pend_q   <= pend_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Active word 0 occupies the most significant slot of each channel's slice.
    always_comb begin
        pattern_o = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            for (int unsigned w = 0; w < PAT_REGS; w++) begin
                pattern_o[(c*PAT_REGS + PAT_REGS - 1 - w)*REG_WIDTH +: REG_WIDTH] = active_q[c][w];
            end
        end
    end

    assign wrken_o                    = en_q;
    assign amm_slave_if.readdata      = rdata_q;
    assign amm_slave_if.readdatavalid = rvalid_q;
    assign amm_slave_if.waitrequest   = 1'b0;
endmodule
